// File: rtl/sar_signed_search.sv
// sar_signed_search
//
// Successive-approximation controller. It recovers an unknown signed
// two's-complement value A by driving the B operand (probe) of an external
// signed "A > B" comparator and resolving one bit per comparison, MSB first.
//
// The search works on the offset-binary image u = A ^ msb. For bit i the
// candidate is t = trial | (1 << i), and the test u >= t is posed to the
// comparator as A > (t - 1), with the operand converted back to signed form.
//
// Parameters:
//   WIDTH   operand width in bits, two's complement (2..16)
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous active-high reset
//   start   request a new search (sampled only while idle)
//   cmp_gt  comparator result: 1 when A > probe (signed)
//   probe   registered B operand for the comparator
//   busy    high while a search is in progress
//   done    one-cycle pulse when result becomes valid
//   result  recovered signed value, held until the next accepted start
//
// Build option:
//   SAR_REG_CMP_EN  when defined, each bit takes two cycles. The first cycle
//                   presents probe, and a flopped copy of cmp_gt resolves the
//                   bit in the second. This suits a registered or long-path
//                   comparator.

module sar_signed_search #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             cmp_gt,
    output logic [WIDTH-1:0] probe,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned      IdxW    = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MsbMask = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] One     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [IdxW-1:0]  TopIdx  = IdxW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StCmp, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] trial_q;
    logic [IdxW-1:0]  bitidx_q;

    logic             gt_eff;
    logic             resolve;
    logic [WIDTH-1:0] cur_bit;
    logic [WIDTH-1:0] trial_nxt;
    logic [WIDTH-1:0] probe_nxt;

`ifdef SAR_REG_CMP_EN
    logic phase_q;  // 0: probe presented, 1: resolve using the flopped compare
    logic gt_q;

    assign gt_eff  = gt_q;
    assign resolve = phase_q;
`else
    assign gt_eff  = cmp_gt;
    assign resolve = 1'b1;
`endif

    always_comb begin
        cur_bit   = One << bitidx_q;
        trial_nxt = gt_eff ? (trial_q | cur_bit) : trial_q;
        // Next candidate sets the bit below the current one. t >= 1 always,
        // so t - 1 never wraps.
        probe_nxt = ((trial_nxt | (cur_bit >> 1)) - One) ^ MsbMask;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            trial_q  <= '0;
            bitidx_q <= '0;
            probe    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
`ifdef SAR_REG_CMP_EN
            phase_q  <= 1'b0;
            gt_q     <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    done  <= 1'b0;
                    probe <= '0;
                    if (start) begin
                        state_q  <= StCmp;
                        busy     <= 1'b1;
                        trial_q  <= '0;
                        bitidx_q <= TopIdx;
                        // First candidate is msb alone: (msb - 1) ^ msb = all ones (-1).
                        probe    <= '1;
`ifdef SAR_REG_CMP_EN
                        phase_q  <= 1'b0;
`endif
                    end
                end
                StCmp: begin
`ifdef SAR_REG_CMP_EN
                    if (!phase_q) begin
                        gt_q <= cmp_gt;
                    end
                    phase_q <= ~phase_q;
`endif
                    if (resolve) begin
                        trial_q <= trial_nxt;
                        if (bitidx_q == '0) begin
                            state_q <= StDone;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            result  <= trial_nxt ^ MsbMask;
                            probe   <= '0;
                        end else begin
                            bitidx_q <= bitidx_q - 1'b1;
                            probe    <= probe_nxt;
                        end
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar_signed_search.sv
// Testbench for sar_signed_search (WIDTH=4) with a combinational signed
// comparator model. Expected probes and results are queued when a search is
// started and popped as the DUT produces them.

module tb_sar_signed_search;

    localparam int W = 4;
`ifdef SAR_REG_CMP_EN
    localparam int Cpb = 2;
`else
    localparam int Cpb = 1;
`endif

    logic         clk;
    logic         reset;
    logic         start;
    logic         cmp_gt;
    logic [W-1:0] probe;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    logic signed [W-1:0] a;

    int checks;
    int errors;

    logic [W-1:0] probe_q[$];
    logic [W-1:0] res_q[$];

    sar_signed_search #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .cmp_gt(cmp_gt),
        .probe (probe),
        .busy  (busy),
        .done  (done),
        .result(result)
    );

    assign cmp_gt = ($signed(a) > $signed(probe));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Probe for bit i: bits of u above i kept, bit i set, minus one, back to signed.
    function automatic logic [W-1:0] model_probe(input logic [W-1:0] av, input int i);
        int u;
        int t;
        u = int'(av ^ 4'h8);
        t = ((u >> (i + 1)) << (i + 1)) | (1 << i);
        return 4'((t - 1) ^ 8);
    endfunction

    task automatic push_model(input logic [W-1:0] av);
        for (int i = W - 1; i >= 0; i--) probe_q.push_back(model_probe(av, i));
        res_q.push_back(av);
    endtask

    // Runs one search from IDLE at a negedge. extra_start >= 0 pulses start
    // again in that CMP cycle (it must be ignored).
    task automatic do_search(input logic [W-1:0] av, input int extra_start);
        logic [W-1:0] exp;
        int cyc;
        a = av;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        for (int b = 0; b < W; b++) begin
            exp = probe_q.pop_front();
            for (int r = 0; r < Cpb; r++) begin
                start = (cyc == extra_start);
                chk("busy_cmp", 32'(busy), 32'd1);
                chk("done_cmp", 32'(done), 32'd0);
                chk($sformatf("probe_a%0d_b%0d", $signed(av), b), 32'(probe), 32'(exp));
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_done", 32'(busy), 32'd0);
        chk($sformatf("result_a%0d", $signed(av)), 32'(result), 32'(res_q.pop_front()));
        @(negedge clk);
        chk("done_low", 32'(done), 32'd0);
        chk("probe_idle", 32'(probe), 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        start  = 1'b0;
        a      = '0;
        repeat (2) @(negedge clk);
        chk("rst_probe", 32'(probe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // A=5: literal probe sequence -1, 3, 5, 4
        probe_q.push_back(4'hF);
        probe_q.push_back(4'h3);
        probe_q.push_back(4'h5);
        probe_q.push_back(4'h4);
        res_q.push_back(4'b0101);
        do_search(4'sd5, -1);

        // Most negative: -1, -5, -7, -8
        probe_q.push_back(4'hF);
        probe_q.push_back(4'hB);
        probe_q.push_back(4'h9);
        probe_q.push_back(4'h8);
        res_q.push_back(4'b1000);
        do_search(4'b1000, -1);

        // Extremes, first probe -1 in both
        push_model(4'b0111);
        chk("model_first_probe_7", 32'(probe_q[0]), 32'hF);
        do_search(4'b0111, -1);
        push_model(4'b1111);
        chk("model_first_probe_m1", 32'(probe_q[0]), 32'hF);
        do_search(4'b1111, -1);

        // Directed A=-3 (the two-cycle build expects 4'b1101 too)
        push_model(4'b1101);
        res_q[0] = 4'b1101;
        do_search(4'b1101, -1);

        // Full sweep, back-to-back: each search starts in the IDLE cycle after done
        for (int v = -8; v <= 7; v++) begin
            push_model(4'(v));
            do_search(4'(v), -1);
        end

        // start during CMP is ignored
        push_model(4'b0011);
        do_search(4'b0011, 1);
        push_model(4'b1010);
        do_search(4'b1010, 2 * Cpb);

        // Reset in the 3rd CMP cycle aborts without a done pulse
        a = 4'sd6;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2 * Cpb) @(negedge clk);
        chk("pre_abort_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_probe", 32'(probe), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        for (int i = 0; i < W * Cpb + 2; i++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done), 32'd0);
            if (i == 1) reset = 1'b0;
        end
        push_model(4'b0110);
        do_search(4'b0110, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sar_signed_search.md
# sar_signed_search

Successive-approximation controller that recovers an unknown signed two's-complement value by querying an external signed "greater-than" comparator. The block drives the comparator's B operand (`probe`), samples its `A > B` output (`cmp_gt`) and resolves one bit per comparison, MSB first. It is the initiator that sits in front of the combinational signed comparator: the unknown value drives A, and this block owns B and the comparison sequence.

## Interface
- `WIDTH`, default 4: operand width in bits, two's complement; legal range 2..16.

- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: request a new search; sampled only in IDLE.
- `cmp_gt` input 1: comparator result, 1 when unknown A > `probe` (signed).
- `probe` output WIDTH: registered B operand driven to the comparator.
- `busy` output 1: high while a search is in progress.
- `done` output 1: one-cycle pulse when `result` becomes valid.
- `result` output WIDTH: recovered signed value; held until the next accepted `start`.

## Operation
- Internal state: `trial[WIDTH-1:0]` (offset-binary accumulator), `bitidx` (down-counter), FSM {IDLE, CMP, DONE}.
- The search runs in the offset-binary domain, u = A ^ (1 << (WIDTH-1)). For bit i, candidate t = trial | (1 << i). The block tests u >= t, which is equivalent to A > (t-1) in the signed domain.
- `probe` = (t - 1) ^ (1 << (WIDTH-1)). t >= 1 always, so the subtraction never underflows.
- IDLE: `probe`=0, `busy`=0. If `start`=1, clear `trial`, set `bitidx`=WIDTH-1, and go to CMP.
- CMP: on each edge, if `cmp_gt`=1 set `trial[bitidx]`, otherwise leave it clear. If `bitidx`=0, go to DONE; otherwise decrement `bitidx`. `probe` is updated registered for the next bit.
- DONE: `result` <= `trial` ^ (1 << (WIDTH-1)), `done`=1 for exactly one cycle, then return to IDLE. In IDLE, `probe` returns to 0.
- `start` while `busy`=1 or in DONE is ignored, with no queuing.
- `cmp_gt` is ignored outside CMP.
- Reset, including mid-search, returns the FSM to IDLE immediately. Reset values: `probe`=0, `busy`=0, `done`=0, `result`=0, `trial`=0. An aborted search produces no `done` pulse.

## Timing
- `start` sampled high at edge k: `busy` rises after edge k and the first `probe` is valid during cycle k+1.
- The external comparator is combinational. `cmp_gt` for the current `probe` is sampled at the end of the same cycle.
- One bit per cycle: CMP occupies cycles k+1 .. k+WIDTH.
- `done`=1 and `result` valid during cycle k+WIDTH+1. `busy` is low during that cycle, so back-to-back `start` is accepted at the DONE edge+1, i.e. IDLE in cycle k+WIDTH+2.
- Total latency from `start` to `done` is WIDTH+1 cycles.

## Configuration
- Macro: `SAR_REG_CMP_EN`.
- Defined: each bit takes two CMP cycles. Cycle 1 presents `probe`. In cycle 2, a flopped copy of `cmp_gt` captured at the end of cycle 1 resolves the bit. This supports a registered or long-path comparator. CMP lasts 2*WIDTH cycles and latency is 2*WIDTH+1. `probe` is held stable across both cycles.
- Undefined: one cycle per bit as specified above, with no `cmp_gt` flop.

## Test plan
- WIDTH=4, model comparator A=5. Pulse `start`: `probe` sequence -1, 3, 5, 4; `done` 5 cycles after `start`; `result`=4'b0101.
- Sweep A across all values -8..7. Confirm `result`==A every time, and that the most negative value gives `probe` sequence -1, -5, -7, -8 with `result`=4'b1000.
- A=7 and A=-1: `result`=4'b0111 and 4'b1111 respectively; the first `probe` is -1 in both cases.
- Assert `reset` during the 3rd CMP cycle: `busy`/`probe`/`result` go to 0 immediately, no `done` pulse. A following `start` completes normally.
- Pulse `start` again during CMP: it is ignored, and the sequence and `result` are unchanged. Assert `start` the cycle after `done`: a new search is accepted.
- With `SAR_REG_CMP_EN` defined and A=-3: each `probe` is held for 2 cycles, `done` arrives 9 cycles after `start`, and `result`=4'b1101.
